// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master arbiter and its helpers.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                // The winner drops to lowest priority for the next round.
                ptr_d = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
            end
        end
        if (!advance || !found) begin
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with round-robin
// arbitration, a registered IDLE/SETUP/ACCESS FSM and a wait-state watchdog.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT);

    apb_state_e          state_q, state_d;
    logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [GW-1:0]       gidx_q, gidx_d;
    logic [WW-1:0]       wd_q, wd_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;

    logic [NUM_REQ-1:0]  arb_req, grant;
    logic                advance;
    logic [GW-1:0]       gsel;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Arbitration only runs in IDLE, so the requester being served is ignored.
    always_comb begin
        arb_req   = (state_q == IDLE) ? req_valid : '0;
        advance   = (state_q == IDLE) && (|req_valid) && !PRESET;
        req_ready = ((state_q == IDLE) && !PRESET) ? grant : '0;
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (PCLK),
        .rst     (PRESET),
        .req     (arb_req),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        gsel      = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gsel      = GW'(i);
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        gidx_d        = gidx_q;
        wd_d          = wd_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (|grant) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = sel_write;
                    paddr_d  = sel_addr;
                    pwdata_d = sel_wdata;
                    gidx_d   = gsel;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wd_d      = '0;
            end
            ACCESS: begin
                // A late PREADY on the final watchdog cycle still completes normally.
                if (PREADY) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << gidx_q;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end else if (wd_q == WW'(TIMEOUT-1)) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = NUM_REQ'(1) << gidx_q;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            gidx_q        <= '0;
            wd_q          <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            gidx_q        <= gidx_d;
            wd_q          <= wd_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a response scoreboard and a simple APB slave.
module tb_apb_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                      PCLK;
    logic                      PRESET;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    apb_master_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    typedef struct {
        logic [NUM_REQ-1:0] oh;
        logic [DATA_W-1:0]  rdata;
        logic               err;
        logic               to;
        int                 cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          wait_cfg  = 0;
    int          acc_cnt   = 0;
    logic [31:0] rdata_cfg = '0;
    logic        err_cfg   = 1'b0;
    logic [31:0] cur_addr  = '0;
    logic [31:0] cur_d     = '0;
    logic        cur_w     = 1'b0;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // APB slave: PREADY rises after wait_cfg wait states in ACCESS.
    always @(negedge PCLK) begin
        if (PSEL === 1'b1 && PENABLE === 1'b1) acc_cnt = acc_cnt + 1;
        else acc_cnt = 0;
        PREADY  = (PSEL === 1'b1) && (PENABLE === 1'b1) && (acc_cnt > wait_cfg);
        PRDATA  = rdata_cfg;
        PSLVERR = err_cfg;
    end

    // Bus-hold and response monitor.
    always @(negedge PCLK) begin
        if (PSEL === 1'b1) begin
            check("paddr_hold", PADDR, cur_addr);
            check("pwrite_hold", PWRITE, cur_w);
            check("pwdata_hold", PWDATA, cur_d);
        end
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_valid_onehot", rsp_valid, mon_e.oh);
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_err", rsp_err, mon_e.err);
                check("rsp_timeout", rsp_timeout, mon_e.to);
                check("rsp_cycle", cyc, mon_e.cyc);
                check("rsp_psel_low", PSEL, 0);
            end
        end
    end

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    task automatic set_req(input int r, input bit w, input logic [31:0] a, input logic [31:0] d);
        req_write[r]           = w;
        req_addr[r*32 +: 32]   = a;
        req_wdata[r*32 +: 32]  = d;
    endtask

    task automatic note_grant(input int r, input bit w, input logic [31:0] a,
                              input logic [31:0] d, input bit exp_rsp);
        exp_t e;
        bit   to;
        cur_addr = a;
        cur_w    = w;
        cur_d    = d;
        if (exp_rsp) begin
            to      = (wait_cfg >= TIMEOUT);
            e.oh    = 4'b0001 << r;
            e.rdata = (w || to) ? 32'h0 : rdata_cfg;
            e.err   = to ? 1'b1 : err_cfg;
            e.to    = to;
            e.cyc   = cyc + (to ? 2 + TIMEOUT : 3 + wait_cfg);
            sb.push_back(e);
        end
    endtask

    task automatic issue(input int r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit exp_rsp);
        int n   = 0;
        bit got = 0;
        set_req(r, w, a, d);
        req_valid[r] = 1'b1;
        while (!got && n < 64) begin
            #1;
            if (req_ready[r]) begin
                got = 1;
                check($sformatf("ready_onehot_r%0d", r), req_ready, 4'b0001 << r);
                note_grant(r, w, a, d, exp_rsp);
            end
            tick();
            n++;
        end
        req_valid[r] = 1'b0;
        if (!got) check("grant_bound", 0, 1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check("rsp_bound", sb.size(), 0);
    endtask

    initial begin
        int exp_r;
        int n;
        PRESET    = 1'b1;
        req_valid = 4'b0001;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        tick();
        tick();
        check("reset_req_ready", req_ready, 0);
        check("reset_psel", PSEL, 0);
        check("reset_penable", PENABLE, 0);
        check("reset_paddr", PADDR, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        PRESET    = 1'b0;
        req_valid = '0;
        tick();
        #1;
        check("idle_no_ready", req_ready, 0);

        // Single write, no wait states.
        wait_cfg = 0;
        err_cfg  = 1'b0;
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        check("wr_setup_psel", PSEL, 1);
        check("wr_setup_penable", PENABLE, 0);
        tick();
        check("wr_access_psel", PSEL, 1);
        check("wr_access_penable", PENABLE, 1);
        req_valid = 4'b0001;
        #1;
        check("busy_ignores_req", req_ready, 0);
        req_valid = '0;
        wait_idle(16);

        // Read with three wait states.
        wait_cfg  = 3;
        rdata_cfg = 32'h12345678;
        issue(2, 1'b0, 32'h20, 32'h0, 1'b1);
        wait_idle(32);

        // Watchdog timeout, then normal service resumes.
        wait_cfg  = 1000;
        rdata_cfg = 32'h55555555;
        issue(3, 1'b0, 32'h30, 32'h0, 1'b1);
        wait_idle(64);

        // Contention: all four held, pointer starts at 0.
        wait_cfg  = 0;
        rdata_cfg = 32'hCAFE0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, (i % 2) == 0, 32'h100 + i * 4, 32'hA0000000 + i);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_r = k % NUM_REQ;
            n = 0;
            #1;
            while (req_ready == '0 && n < 64) begin
                tick();
                #1;
                n++;
            end
            check("contend_grant", req_ready, 4'b0001 << exp_r);
            note_grant(exp_r, (exp_r % 2) == 0, 32'h100 + exp_r * 4, 32'hA0000000 + exp_r, 1'b1);
            tick();
        end
        req_valid = '0;
        wait_idle(16);

        // Slave error on a write from requester 1.
        err_cfg = 1'b1;
        issue(1, 1'b1, 32'h40, 32'h11112222, 1'b1);
        wait_idle(16);
        err_cfg = 1'b0;

        // Reset during ACCESS aborts the transfer and rewinds the pointer.
        wait_cfg = 1000;
        issue(2, 1'b0, 32'h80, 32'h0, 1'b0);
        tick();
        check("abort_in_access", PENABLE, 1);
        PRESET = 1'b1;
        tick();
        check("abort_psel", PSEL, 0);
        check("abort_penable", PENABLE, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        req_valid = 4'b1111;
        #1;
        check("reset_blocks_ready", req_ready, 0);
        PRESET   = 1'b0;
        wait_cfg = 0;
        #1;
        check("post_reset_grant", req_ready, 4'b0001);
        note_grant(0, 1'b1, 32'h100, 32'hA0000000, 1'b1);
        tick();
        req_valid = '0;
        wait_idle(16);

        tick();
        tick();
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
